data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: valid/ready load/store port with programmable wait states,
// word/byte accesses, base-address offset and range/alignment fault checking.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AddrW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        wr_q, byte_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, commit;
  logic             c_wr, c_byte, c_err;
  logic [31:0]      c_addr, c_wdata, off, rd_word, rd_data;
  logic [AddrW-1:0] widx;
  logic [1:0]       lane;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept     = 1'b1;
          wait_cnt_d = WaitInit;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            commit  = 1'b1;
          end
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      c_wr    = req_wr;
      c_byte  = req_byte;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_wr    = wr_q;
      c_byte  = byte_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
    off     = c_addr - BASE_ADDR;
    widx    = off[AddrW+1:2];
    lane    = off[1:0];
    c_err   = (c_addr < BASE_ADDR) | (off >= SpanBytes) | (!c_byte & (lane != 2'd0));
    rd_word = mem[widx];
    rd_data = c_byte ? {24'd0, rd_word[{lane, 3'b000} +: 8]} : rd_word;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        wr_q    <= req_wr;
        byte_q  <= req_byte;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (c_wr | c_err) ? 32'd0 : rd_data;
      end
    end
  end

  // RAM is never cleared; Reset only blocks a store on the commit edge.
  always_ff @(posedge clk) begin
    if (!Reset && commit && c_wr && !c_err) begin
      if (c_byte) mem[widx][{lane, 3'b000} +: 8] <= c_wdata[7:0];
      else        mem[widx] <= c_wdata;
    end
  end

  assign req_ready = (state_q == StIdle) & ~Reset;
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
